// File: rtl/sw_bcast_arbiter.sv
// Arbitrates N_CORE store queues onto the single data_mem write broadcast and owns the
// SINGLE/PAR/DRAIN mode switch. Define SW_BCAST_ARB_STATS_EN to add grant/stall counters.
module sw_bcast_arbiter #(
  parameter int unsigned N_CORE = 4,
  parameter int unsigned ADDR_W = 17,
  parameter int unsigned DATA_W = 32
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        parallel_i,
  input  logic [N_CORE-1:0]           req_valid_i,
  input  logic [N_CORE*ADDR_W-1:0]    req_addr_i,
  input  logic [N_CORE*DATA_W-1:0]    req_data_i,
  output logic [N_CORE-1:0]           req_ready_o,
  output logic                        bcast_valid_o,
  output logic [ADDR_W-1:0]           bcast_addr_o,
  output logic [DATA_W-1:0]           bcast_data_o,
  output logic [$clog2(N_CORE)-1:0]   bcast_src_o,
  output logic                        mode_par_o,
  output logic                        drain_busy_o
`ifdef SW_BCAST_ARB_STATS_EN
  ,
  output logic [N_CORE*32-1:0]        grant_cnt_o,
  output logic [31:0]                 stall_cnt_o
`endif
);

  localparam int unsigned SRC_W = $clog2(N_CORE);

  typedef enum logic [1:0] {
    ST_SINGLE = 2'd0,
    ST_PAR    = 2'd1,
    ST_DRAIN  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [SRC_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic                bcast_valid_q;
  logic [ADDR_W-1:0]   bcast_addr_q;
  logic [DATA_W-1:0]   bcast_data_q;
  logic [SRC_W-1:0]    bcast_src_q;
  logic                mode_par_q;
  logic                drain_busy_q;

  logic                grant_any;
  logic [SRC_W-1:0]    grant_idx;
  logic [N_CORE-1:0]   grant_vec;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_data;

  // Grant: core 0 only in SINGLE, round-robin from rr_ptr otherwise; nothing during reset.
  always_comb begin
    logic [SRC_W-1:0] cand;
    grant_any = 1'b0;
    grant_idx = '0;
    grant_vec = '0;
    cand      = '0;
    if (!reset_i) begin
      if (state_q == ST_SINGLE) begin
        grant_any = req_valid_i[0];
      end else begin
        for (int unsigned i = 0; i < N_CORE; i++) begin
          cand = rr_ptr_q + SRC_W'(i);
          if (!grant_any && req_valid_i[cand]) begin
            grant_any = 1'b1;
            grant_idx = cand;
          end
        end
      end
      if (grant_any) grant_vec[grant_idx] = 1'b1;
    end
  end

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int unsigned i = 0; i < N_CORE; i++) begin
      if (grant_idx == SRC_W'(i)) begin
        sel_addr = req_addr_i[i*ADDR_W +: ADDR_W];
        sel_data = req_data_i[i*DATA_W +: DATA_W];
      end
    end
  end

  // Next-state: DRAIN falls back to SINGLE only once every queue is empty.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = grant_any ? grant_idx + SRC_W'(1) : rr_ptr_q;
    unique case (state_q)
      ST_SINGLE: if (parallel_i) state_d = ST_PAR;
      ST_PAR:    if (!parallel_i) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (parallel_i)                              state_d = ST_PAR;
        else if ((req_valid_i == '0) && !grant_any)  state_d = ST_SINGLE;
      end
      default:   state_d = ST_SINGLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q       <= ST_SINGLE;
      rr_ptr_q      <= '0;
      bcast_valid_q <= 1'b0;
      bcast_addr_q  <= '0;
      bcast_data_q  <= '0;
      bcast_src_q   <= '0;
      mode_par_q    <= 1'b0;
      drain_busy_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      bcast_valid_q <= grant_any;
      if (grant_any) begin
        bcast_addr_q <= sel_addr;
        bcast_data_q <= sel_data;
        bcast_src_q  <= grant_idx;
      end
      mode_par_q    <= (state_d == ST_PAR);
      drain_busy_q  <= (state_d == ST_DRAIN);
    end
  end

  assign req_ready_o   = grant_vec;
  assign bcast_valid_o = bcast_valid_q;
  assign bcast_addr_o  = bcast_addr_q;
  assign bcast_data_o  = bcast_data_q;
  assign bcast_src_o   = bcast_src_q;
  assign mode_par_o    = mode_par_q;
  assign drain_busy_o  = drain_busy_q;

`ifdef SW_BCAST_ARB_STATS_EN
  logic [N_CORE-1:0][31:0] grant_cnt_q;
  logic [31:0]             stall_cnt_q;

  // Saturating counters: accepted stores per core, and stalled cycles with pending requests.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      grant_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      for (int unsigned i = 0; i < N_CORE; i++) begin
        if (grant_vec[i] && (grant_cnt_q[i] != 32'hFFFF_FFFF))
          grant_cnt_q[i] <= grant_cnt_q[i] + 32'd1;
      end
      if ((req_valid_i != '0) && !grant_any && (stall_cnt_q != 32'hFFFF_FFFF))
        stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign grant_cnt_o = grant_cnt_q;
  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_sw_bcast_arbiter.sv
// Randomized bench for sw_bcast_arbiter: a mode/round-robin reference model feeds a
// per-cycle expectation queue that an independent monitor drains and compares.
module tb_sw_bcast_arbiter;
  localparam int unsigned N    = 4;
  localparam int unsigned AW   = 17;
  localparam int unsigned DW   = 32;
  localparam int unsigned SW   = 2;
  localparam int          NCYC = 4000;

  logic              clk = 1'b0;
  logic              reset_i;
  logic              parallel_i;
  logic [N-1:0]      req_valid_i;
  logic [N*AW-1:0]   req_addr_i;
  logic [N*DW-1:0]   req_data_i;
  logic [N-1:0]      req_ready_o;
  logic              bcast_valid_o;
  logic [AW-1:0]     bcast_addr_o;
  logic [DW-1:0]     bcast_data_o;
  logic [SW-1:0]     bcast_src_o;
  logic              mode_par_o;
  logic              drain_busy_o;
`ifdef SW_BCAST_ARB_STATS_EN
  logic [N*32-1:0]   grant_cnt_o;
  logic [31:0]       stall_cnt_o;
`endif

  always #5 clk = ~clk;

  sw_bcast_arbiter #(.N_CORE(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk_i(clk), .reset_i(reset_i), .parallel_i(parallel_i),
    .req_valid_i(req_valid_i), .req_addr_i(req_addr_i), .req_data_i(req_data_i),
    .req_ready_o(req_ready_o), .bcast_valid_o(bcast_valid_o), .bcast_addr_o(bcast_addr_o),
    .bcast_data_o(bcast_data_o), .bcast_src_o(bcast_src_o), .mode_par_o(mode_par_o),
    .drain_busy_o(drain_busy_o)
`ifdef SW_BCAST_ARB_STATS_EN
    , .grant_cnt_o(grant_cnt_o), .stall_cnt_o(stall_cnt_o)
`endif
  );

  typedef struct {
    bit          v;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [SW-1:0] s;
    bit          mp;
    bit          db;
    int unsigned gc[N];
    int unsigned sc;
  } exp_t;

  exp_t exp_q[$];
  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  // Stimulus and reference model; mode 0=SINGLE, 1=PAR, 2=DRAIN.
  initial begin
    int            m_mode, m_rr, g, dens;
    bit            hold, rst, par, have_pend;
    bit            hp[N];
    logic [AW-1:0] ha[N];
    logic [DW-1:0] hd[N];
    logic [N-1:0]  v, exp_rdy;
    logic [AW-1:0] last_a;
    logic [DW-1:0] last_d;
    logic [SW-1:0] last_s;
    int unsigned   gc[N];
    int unsigned   sc;
    exp_t          pend;

    m_mode = 0; m_rr = 0; dens = 2; hold = 0; par = 0; have_pend = 0;
    last_a = '0; last_d = '0; last_s = '0; sc = 0;
    for (int k = 0; k < N; k++) begin hp[k] = 0; ha[k] = '0; hd[k] = '0; gc[k] = 0; end
    reset_i = 1'b1; parallel_i = 1'b0; req_valid_i = '0; req_addr_i = '0; req_data_i = '0;

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(posedge clk);
      if (have_pend) exp_q.push_back(pend);
      #1;
      if (cyc % 100 == 0) begin
        dens = $urandom_range(0, 4);
        hold = 1'($urandom_range(0, 1));
      end
      rst = (cyc < 2) || ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 15) == 0) par = ~par;
      for (int k = 0; k < N; k++) begin
        if (hold) begin
          if (!hp[k] && ($urandom_range(0, 3) < dens)) begin
            hp[k] = 1;
            ha[k] = AW'($urandom);
            hd[k] = $urandom;
          end
          v[k] = hp[k];
        end else begin
          hp[k] = 0;
          v[k]  = ($urandom_range(0, 3) < dens);
          ha[k] = AW'($urandom);
          hd[k] = $urandom;
        end
        req_addr_i[k*AW +: AW] = ha[k];
        req_data_i[k*DW +: DW] = hd[k];
      end
      reset_i     = rst;
      parallel_i  = par;
      req_valid_i = v;
      #1;

      g = -1;
      if (!rst) begin
        if (m_mode == 0) begin
          if (v[0]) g = 0;
        end else begin
          for (int i = 0; i < N; i++)
            if (g < 0 && v[(m_rr + i) % N]) g = (m_rr + i) % N;
        end
      end
      exp_rdy = (g >= 0) ? N'(1 << g) : '0;
      chk("req_ready", 64'(req_ready_o), 64'(exp_rdy));

      if (rst) begin
        m_mode = 0; m_rr = 0; last_a = '0; last_d = '0; last_s = '0; sc = 0;
        for (int k = 0; k < N; k++) gc[k] = 0;
      end else begin
        if (g >= 0) begin
          last_a = ha[g]; last_d = hd[g]; last_s = SW'(g);
          m_rr = (g + 1) % N;
          gc[g]++;
          hp[g] = 0;
        end else if (v != '0) begin
          sc++;
        end
        case (m_mode)
          0: if (par) m_mode = 1;
          1: if (!par) m_mode = 2;
          default: if (par) m_mode = 1; else if (v == '0) m_mode = 0;
        endcase
      end
      pend.v = (g >= 0); pend.a = last_a; pend.d = last_d; pend.s = last_s;
      pend.mp = (m_mode == 1); pend.db = (m_mode == 2);
      for (int k = 0; k < N; k++) pend.gc[k] = gc[k];
      pend.sc = sc;
      have_pend = 1;
    end
    @(posedge clk);
    exp_q.push_back(pend);
    @(negedge clk);
    #1;
    chk("queue_drained", 64'(exp_q.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Monitor: compares registered outputs against the expectation for this cycle.
  initial begin : mon
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("bcast_valid", 64'(bcast_valid_o), 64'(e.v));
        chk("bcast_addr",  64'(bcast_addr_o),  64'(e.a));
        chk("bcast_data",  64'(bcast_data_o),  64'(e.d));
        chk("bcast_src",   64'(bcast_src_o),   64'(e.s));
        chk("mode_par",    64'(mode_par_o),    64'(e.mp));
        chk("drain_busy",  64'(drain_busy_o),  64'(e.db));
`ifdef SW_BCAST_ARB_STATS_EN
        for (int k = 0; k < N; k++)
          chk("grant_cnt", 64'(grant_cnt_o[k*32 +: 32]), 64'(e.gc[k]));
        chk("stall_cnt", 64'(stall_cnt_o), 64'(e.sc));
`endif
      end
    end
  end

endmodule
